// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared definitions for the CPU run-control sequencer.
//   cpu_state_e : 2-bit run-control state (RUN, STEP, HALT; 2'd3 unused/illegal)
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_STEP = 2'd1,
    ST_HALT = 2'd2
  } cpu_state_e;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if: board-side and PC-side signals of the run-control sequencer.
//   master : board/decode side, drives go/step_mode/halt_req/branch_ok/jmp/div
//   slave  : cpu_run_ctrl, drives enable/halted/state and the statistics counters
interface cpu_run_ctrl_if #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned DIV_W = 4
);
  logic             go;
  logic             step_mode;
  logic             halt_req;
  logic             branch_ok;
  logic             jmp;
  logic [DIV_W-1:0] div;
  logic             enable;
  logic             halted;
  logic [1:0]       state;
  logic [CNT_W-1:0] instr_cnt;
  logic [CNT_W-1:0] jmp_cnt;
  logic [CNT_W-1:0] branch_cnt;

  modport master (
    output go, step_mode, halt_req, branch_ok, jmp, div,
    input  enable, halted, state, instr_cnt, jmp_cnt, branch_cnt
  );

  modport slave (
    input  go, step_mode, halt_req, branch_ok, jmp, div,
    output enable, halted, state, instr_cnt, jmp_cnt, branch_cnt
  );
endinterface

// File: rtl/cpu_run_ctrl_rate_div.sv
// rate_div: free-run rate divider for the PC.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : hold the count at zero (asserted whenever the sequencer is not in RUN)
//   div      : tick once every div+1 cycles
//   tick     : combinational, high when the count has reached div
module rate_div #(
  parameter int unsigned DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] tick_cnt_q, tick_cnt_d;

  // >= rather than == so that lowering div mid-count ticks at once
  // instead of wrapping through the whole counter range.
  assign tick = (tick_cnt_q >= div);

  always_comb begin
    tick_cnt_d = tick_cnt_q + 1'b1;
    if (clr || tick) tick_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tick_cnt_q <= '0;
    else      tick_cnt_q <= tick_cnt_d;
  end
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run-control sequencer for the single-cycle MIPS PC.
//   clk, rst : clock (rising edge), asynchronous active-low reset
//   bus      : cpu_run_ctrl_if.slave
//     go/step_mode/halt_req/branch_ok/jmp/div in; enable (PC write enable,
//     combinational), halted/state (registered), instr_cnt/jmp_cnt/branch_cnt out.
// Build option: define CPU_STATS_EN to build the saturating statistics
// counters; without it the three counter outputs are tied to zero.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned DIV_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  cpu_run_ctrl_if.slave  bus
);
  cpu_state_e state_q, state_d;
  logic       halted_q, halted_d;
  logic       go_q, go_d;
  logic       go_pulse;
  logic       tick;
  logic       en_c;

  assign go_pulse = bus.go & ~go_q;
  assign go_d     = bus.go;

  rate_div #(.DIV_W(DIV_W)) u_rate_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q != ST_RUN),
    .div  (bus.div),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    en_c    = 1'b0;
    case (state_q)
      ST_RUN: begin
        en_c = tick & ~bus.halt_req;
        if (bus.halt_req)       state_d = ST_HALT;
        else if (bus.step_mode) state_d = ST_STEP;
      end
      ST_STEP: begin
        en_c = go_pulse & ~bus.halt_req;
        if (bus.halt_req)        state_d = ST_HALT;
        else if (!bus.step_mode) state_d = ST_RUN;
      end
      ST_HALT: begin
        // The resume press steps past the syscall even though decode
        // still reports it as a halt.
        en_c = go_pulse;
        if (go_pulse) state_d = bus.step_mode ? ST_STEP : ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      halted_q <= 1'b0;
      go_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      go_q     <= go_d;
    end
  end

  // Reset holds state at RUN with the divider at zero, which would otherwise
  // tick with div=0; gate explicitly so the PC cannot move during reset.
  assign bus.enable = rst & en_c;
  assign bus.halted = halted_q;
  assign bus.state  = state_q;

`ifdef CPU_STATS_EN
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic [CNT_W-1:0] jmp_cnt_q, jmp_cnt_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;

  always_comb begin
    instr_cnt_d  = instr_cnt_q;
    jmp_cnt_d    = jmp_cnt_q;
    branch_cnt_d = branch_cnt_q;
    if (bus.enable) begin
      if (instr_cnt_q != '1)                  instr_cnt_d  = instr_cnt_q + 1'b1;
      if (bus.jmp && (jmp_cnt_q != '1))       jmp_cnt_d    = jmp_cnt_q + 1'b1;
      if (bus.branch_ok && (branch_cnt_q != '1)) branch_cnt_d = branch_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_cnt_q  <= '0;
      jmp_cnt_q    <= '0;
      branch_cnt_q <= '0;
    end else begin
      instr_cnt_q  <= instr_cnt_d;
      jmp_cnt_q    <= jmp_cnt_d;
      branch_cnt_q <= branch_cnt_d;
    end
  end

  assign bus.instr_cnt  = instr_cnt_q;
  assign bus.jmp_cnt    = jmp_cnt_q;
  assign bus.branch_cnt = branch_cnt_q;
`else
  logic unused_stats;
  assign unused_stats   = bus.jmp ^ bus.branch_ok;
  assign bus.instr_cnt  = '0;
  assign bus.jmp_cnt    = '0;
  assign bus.branch_cnt = '0;
`endif
endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run-control sequencer for the single-cycle MIPS CPU's program counter. It drives the PC register's `enable` and decides when the PC may advance:
- free-running at a programmable rate;
- single-stepped from a board button;
- halted on a syscall-halt request and resumed.

It sits between the board I/O (buttons/switches) and the PC unit. It also keeps execution statistics (instructions retired, jumps, taken branches) for the seven-segment display.

## Interface
Parameters:
- `CNT_W`, 32, width of each statistics counter
- `DIV_W`, 4, width of the rate-divider setting

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `go`  in  1  synchronous, debounced button level; rising edge = step/resume
- `step_mode`  in  1  1 = single-step, 0 = free run
- `halt_req`  in  1  current instruction is syscall-halt (combinational from decode)
- `branch_ok`  in  1  current instruction is a taken conditional branch
- `jmp`  in  1  current instruction is an unconditional jump (J/JAL/JR)
- `div`  in  DIV_W  PC advances once every `div`+1 cycles in RUN
- `enable`  out  1  PC register write enable
- `halted`  out  1  state is HALT
- `state`  out  2  current state encoding
- `instr_cnt`  out  CNT_W  instructions retired
- `jmp_cnt`  out  CNT_W  unconditional jumps retired
- `branch_cnt`  out  CNT_W  taken branches retired

## Operation
- States: RUN=2'd0, STEP=2'd1, HALT=2'd2; 2'd3 is illegal and recovers to RUN on the next edge.
- Go edge: `go_pulse = go & ~go_q`, where `go_q` is `go` registered.
- RUN, rate ticking:
  - `tick_cnt` counts 0..`div`; `tick = (tick_cnt >= div)`.
  - On `tick`, `tick_cnt` returns to 0; otherwise it increments.
  - The `>=` comparison makes a mid-count reduction of `div` tick immediately.
- RUN, enable and transitions:
  - `enable = tick & ~halt_req`.
  - If `halt_req`: next = HALT and `enable` = 0, so the PC stays on the syscall.
  - Else if `step_mode`: next = STEP.
- STEP:
  - `enable = go_pulse & ~halt_req`.
  - If `halt_req`: next = HALT.
  - If `~step_mode`: next = RUN.
- HALT:
  - `enable = go_pulse`. The resume pulse overrides `halt_req` for exactly one cycle, stepping the PC past the syscall.
  - On `go_pulse`: next = STEP if `step_mode`, else RUN.
  - Without `go_pulse`, stay in HALT regardless of `halt_req`.
- `tick_cnt` is cleared whenever state ≠ RUN.
- Statistics, evaluated each cycle with `enable` = 1:
  - `instr_cnt` += 1
  - `jmp_cnt` += `jmp`
  - `branch_cnt` += `branch_ok`
  - All counters saturate at 2^CNT_W−1; no wrap.
- Simultaneous `halt_req` and `go_pulse` in RUN or STEP: halt wins, `enable` = 0, next = HALT. A new press is then required to resume.

## Timing
- `enable` is combinational from registered state, `tick_cnt`, `go_q`, `go` and `halt_req`. This gives zero-cycle latency, so the PC advances on the same edge that ends the enabling cycle.
- `go_pulse` is high only in the first cycle of a `go` high level. Holding `go` gives exactly one step.
- `div`=0 in RUN: `enable` is high every cycle until `halt_req`.
- Counters, `state` and `halted` update on the edge that ends an enabling cycle; they are registered outputs.
- Reset (asserted at any time, including mid-step):
  - state = RUN; `tick_cnt`, `go_q` and all counters = 0.
  - Outputs during reset: `halted`=0, `state`=0, `enable`=0 (forced while `rst` is low).
- First `enable` after reset release with `div`=0: first cycle, unless `halt_req` is high.

## Configuration
- `CPU_STATS_EN` defined: the three counters are implemented as above.
- `CPU_STATS_EN` undefined: the counters are not built, and `instr_cnt`, `jmp_cnt` and `branch_cnt` are tied to 0.
- Run/step/halt behaviour is identical either way.

## Structure
- Shared package `cpu_ctrl_pkg`: state encodings (`ST_RUN`, `ST_STEP`, `ST_HALT`) and the 2-bit state typedef.
- One sub-module, `rate_div`: `tick_cnt` with clear input and `div` compare, output `tick`.
- Edge detect, FSM and counters stay in `cpu_run_ctrl`.

## Test plan
- Free run, `div`=3, `halt_req`=0 for 16 cycles after reset → `enable` high in cycles 3,7,11,15; `instr_cnt`=4.
- RUN with `div`=0; `halt_req` rises at cycle 5 → `enable`=0 from cycle 5; state = HALT from cycle 6; `halted`=1. Then a `go` press held 4 cycles → exactly one `enable`; state returns to RUN.
- `step_mode`=1; three `go` presses with `jmp`=1 on the 2nd and `branch_ok`=1 on the 3rd → `instr_cnt`=3, `jmp_cnt`=1, `branch_cnt`=1; no `enable` between presses.
- `go_pulse` coincident with `halt_req` in STEP → `enable`=0; next state HALT; `instr_cnt` unchanged.
- `rst` pulled low mid-run with counters at 7 → immediately `enable`=0 and counters 0; after release, state = RUN.
- `CNT_W`=3, 10 enabled cycles → `instr_cnt` holds at 7.
